snn_result_uart_tx: RTL and testbench
=====================================

Name: snn_result_uart_tx

Overview:
- Monitors the SNN output-buffer write strobe and decimates it to one capture per inference.
- Buffers the captured (p1, p2) result pairs.
- Serialises each pair as a fixed 5-byte UART 8N1 frame on a single line.
- Sits beside the SNN core in the SoC. It is the transmit end of the serial result link that host scripts and the bench UART decoder receive at 57600 baud.

Parameters:
- CLKS_PER_BIT, 386, wb_clk cycles per UART bit (22.22 MHz / 57600, rounded).
- FIFO_DEPTH, 4, number of result pairs buffered; must be a power of 2, ≥2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- wb_clk  in  1  system clock
- wb_rst  in  1  reset, asynchronous, active-high
- valid_snn  in  1  output-buffer write strobe; one pulse per neuron write
- p1  in  16  signed score, class 1; sampled when the strobe is captured
- p2  in  16  signed score, class 2; sampled when the strobe is captured
- n_decim  in  32  strobes per inference (NEURON_4/2); static while enabled
- en  in  1  capture enable; disabling does not abort frames already in progress
- tx  out  1  UART line, idle high
- busy  out  1  high while a frame is being shifted out or the FIFO is non-empty
- overflow  out  1  sticky; set when a capture is dropped
- frame_cnt  out  16  number of frames fully transmitted; wraps at 65535 to 0

Behaviour:
- Reset values: tx=1, busy=0, overflow=0, frame_cnt=0; FIFO empty; decimation counter=0; FSM in IDLE. Reset is asynchronous.
- Decimation: a 32-bit counter dcnt advances on each cycle with valid_snn=1 and en=1.
  - Capture when dcnt==0, storing {p1,p2} from that same cycle.
  - Next value: dcnt==n_decim-1 ? 0 : dcnt+1.
  - n_decim==0 is treated as 1, so every strobe is captured.
  - If en=0, dcnt holds.
- FIFO push happens on capture.
  - If the FIFO is full and no pop occurs that cycle: drop the capture, set overflow=1, leave FIFO contents unchanged.
  - If the FIFO is full and a pop occurs the same cycle: accept the push, with no overflow.
- FIFO pop happens in LOAD only. Pointers wrap modulo FIFO_DEPTH. Data becomes visible to LOAD one cycle after the push.
- FSM states:
  - IDLE: tx=1. Go to LOAD when the FIFO is non-empty.
  - LOAD (1 cycle): pop the pair into a 40-bit frame register {SYNC_BYTE, p1[15:8], p1[7:0], p2[15:8], p2[7:0]}. Set byte_idx=0 and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx = current byte, LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<4: byte_idx+1, go to START.
    - Otherwise: frame_cnt+1 and go to NEXT.
  - NEXT (1 cycle): go to LOAD if the FIFO is non-empty, else IDLE.
- Frames go out back-to-back with no gap between bytes. The frame length is exactly 50·CLKS_PER_BIT cycles, plus 1 LOAD cycle and 1 NEXT cycle.
- Latency: tx falls 2 cycles after the capturing valid_snn edge when idle (push → LOAD → START).
- The baud counter counts from 0 to CLKS_PER_BIT-1. The bit changes on the wrap.
- The tx output is registered, so there are no glitches.

Decomposition:
- Package snn_uart_pkg holds:
  - FSM state enum: IDLE, LOAD, START, DATA, STOP, NEXT
  - FRAME_BYTES=5
  - default SYNC_BYTE
  - the CLKS_PER_BIT calculation helper
- Sub-module snn_result_fifo: synchronous, single clock, width 32, depth FIFO_DEPTH, with full/empty flags and same-cycle push/pop.
- FSM, decimator and shifter live at the top level.

Test Plan:
- Single result, n_decim=1: one valid_snn with p1=16'sh0123, p2=-2 (16'hFFFE).
  - Required: decoded bytes A5 01 23 FF FE.
  - Start bit begins 2 cycles after the strobe.
  - frame_cnt=1 after 50·386+2 cycles.
  - busy then drops.
- Decimation, n_decim=150: 450 strobes with p1 = strobe index.
  - Required: exactly 3 frames, with p1=0, 150, 300.
- Overflow: FIFO_DEPTH=4, n_decim=1, 6 strobes on consecutive cycles.
  - Required: the first 5 are accepted (one popped by LOAD before the FIFO fills) and the 6th is dropped.
  - overflow=1; 5 frames are sent, in order.
- Full with simultaneous pop: strobe aligned to the LOAD cycle while the FIFO is full.
  - Required: push accepted, overflow stays 0.
- Reset mid-frame: assert wb_rst during DATA of byte 2.
  - Required: tx=1 immediately (asynchronous), frame_cnt=0, FIFO empty.
  - After release, the next strobe yields a clean, complete frame.
- n_decim=0 and en=0: with en=0, strobes produce no frames and dcnt holds.
  - With en=1 and n_decim=0, every strobe produces a frame.

Source files
------------

// File: rtl/snn_uart_pkg.sv
// Shared definitions for the SNN result UART transmitter.
// Holds the transmit FSM state type, the result-pair payload layout,
// the frame geometry, the default sync byte and the baud divisor helper.
package snn_uart_pkg;

    // Transmit sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP,
        NEXT
    } tx_state_e;

    // One captured inference result.
    typedef struct packed {
        logic [15:0] p1;
        logic [15:0] p2;
    } result_t;

    localparam int unsigned FRAME_BYTES       = 5;
    localparam int unsigned FRAME_W           = 8 * FRAME_BYTES;
    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int unsigned DEFAULT_CLK_HZ    = 22_220_000;
    localparam int unsigned DEFAULT_BAUD      = 57_600;

    // Clock cycles per UART bit, rounded to nearest.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int unsigned DEFAULT_CLKS_PER_BIT =
        calc_clks_per_bit(DEFAULT_CLK_HZ, DEFAULT_BAUD);

endpackage

// File: rtl/snn_result_fifo.sv
// Single-clock result FIFO with full/empty flags.
// Ports: clk/rst (async, active-high), push/push_data, pop/pop_data,
// full, empty. A push while full is accepted only if a pop happens in the
// same cycle. Read data is the head entry, visible the cycle after its push.
module snn_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer/count update; pointers wrap naturally since DEPTH is 2^AW.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/snn_result_uart_tx.sv
// SNN result serial link transmitter.
// Decimates the SNN output-buffer write strobe to one capture per inference,
// buffers (p1, p2) pairs and sends each as a 5-byte 8N1 frame:
// {SYNC_BYTE, p1[15:8], p1[7:0], p2[15:8], p2[7:0]}.
// Ports: wb_clk, wb_rst (async, active-high); valid_snn, p1, p2, n_decim, en
// (capture side); tx (UART line), busy, overflow (sticky), frame_cnt.
module snn_result_uart_tx
    import snn_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        valid_snn,
    input  logic [15:0] p1,
    input  logic [15:0] p2,
    input  logic [31:0] n_decim,
    input  logic        en,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT + 1);

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [2:0]           byte_idx_q, byte_idx_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [31:0]          dcnt_q, dcnt_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 overflow_q, overflow_d;

    logic                 strobe;
    logic                 capture;
    logic [31:0]          n_eff;
    logic                 baud_wrap;
    logic [7:0]           cur_byte;
    result_t              cap_res;
    result_t              head_res;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign cap_res.p1 = p1;
    assign cap_res.p2 = p2;

    snn_result_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk),
        .rst       (wb_rst),
        .push      (capture),
        .push_data (cap_res),
        .pop       (fifo_pop),
        .pop_data  (head_res),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decimator: capture on the first strobe of each group of n_decim.
    always_comb begin
        strobe  = valid_snn && en;
        n_eff   = (n_decim == 32'd0) ? 32'd1 : n_decim;
        capture = strobe && (dcnt_q == 32'd0);
        dcnt_d  = dcnt_q;
        if (strobe) begin
            dcnt_d = (dcnt_q == n_eff - 32'd1) ? 32'd0 : dcnt_q + 32'd1;
        end
    end

    // Transmit sequencer; frame register shifts one byte left per byte sent,
    // so the byte on the wire is always the top byte.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        frame_d     = frame_q;
        frame_cnt_d = frame_cnt_q;
        fifo_pop    = 1'b0;
        baud_wrap   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        cur_byte    = frame_q[FRAME_W-1 -: 8];

        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                fifo_pop   = 1'b1;
                frame_d    = {SYNC_BYTE, head_res.p1, head_res.p2};
                byte_idx_d = 3'd0;
                baud_d     = '0;
                state_d    = START;
            end
            START: begin
                if (baud_wrap) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (byte_idx_q < 3'(FRAME_BYTES - 1)) begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        frame_d    = {frame_q[FRAME_W-9:0], 8'h00};
                        state_d    = START;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = NEXT;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            NEXT: begin
                state_d = fifo_empty ? IDLE : LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level for the coming cycle, from the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase

        busy_d     = (state_d != IDLE) || !fifo_empty || capture;
        overflow_d = overflow_q || (capture && fifo_full && !fifo_pop);
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 3'd0;
            frame_q     <= '0;
            dcnt_q      <= 32'd0;
            frame_cnt_q <= 16'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            frame_q     <= frame_d;
            dcnt_q      <= dcnt_d;
            frame_cnt_q <= frame_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_snn_result_uart_tx.sv
// Bench for snn_result_uart_tx: a UART receiver decodes the line, and a
// timeline model (capture rule, bounded queue, frames of fixed length)
// predicts which pairs get sent, overflow and frame_cnt.
module tb_snn_result_uart_tx;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int F     = 50 * N + 2;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        wb_clk;
    logic        wb_rst;
    logic        valid_snn;
    logic [15:0] p1;
    logic [15:0] p2;
    logic [31:0] n_decim;
    logic        en;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [15:0] frame_cnt;

    snn_result_uart_tx #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH),
        .SYNC_BYTE    (SYNC)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .valid_snn (valid_snn),
        .p1        (p1),
        .p2        (p2),
        .n_decim   (n_decim),
        .en        (en),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (edge-indexed timeline) ----------------
    longint      cyc = 0;
    longint      m_last_pop = -1000000;
    longint      m_sched = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_sent[$];
    logic [31:0] m_dcnt = 0;
    logic [31:0] m_nd;
    bit          m_ovf = 0;
    int          m_frames = 0;
    bit          m_pop, m_cap, m_was_empty;

    always @(posedge wb_clk) begin
        cyc++;
        if (wb_rst) begin
            m_q.delete();
            m_sent.delete();
            m_dcnt     = 0;
            m_ovf      = 0;
            m_frames   = 0;
            m_last_pop = -1000000;
        end else begin
            m_was_empty = (m_q.size() == 0);
            m_pop = !m_was_empty && (cyc == m_sched);
            m_cap = 0;
            if (valid_snn && en) begin
                m_nd   = (n_decim == 0) ? 32'd1 : n_decim;
                m_cap  = (m_dcnt == 0);
                m_dcnt = (m_dcnt == m_nd - 1) ? 32'd0 : m_dcnt + 1;
            end
            if (m_pop) begin
                m_sent.push_back(m_q.pop_front());
                m_last_pop = cyc;
                m_sched    = cyc + F;
                m_frames++;
            end
            if (m_cap) begin
                if (m_q.size() < DEPTH) m_q.push_back({p1, p2});
                else m_ovf = 1;
            end
            // Idle start: load two edges after the first push, but never
            // before the previous frame has fully finished.
            if (m_was_empty && m_q.size() != 0)
                m_sched = (cyc + 2 > m_last_pop + F) ? cyc + 2 : m_last_pop + F;
        end
    end

    // ---------------- UART receiver ----------------
    int          d_ph = 0;
    int          d_cnt = 0;
    int          d_bit = 0;
    logic [7:0]  d_sh;
    logic [7:0]  rx_bytes[$];
    logic [39:0] rx_frames[$];

    always @(negedge wb_clk) begin
        if (wb_rst) begin
            d_ph = 0;
            rx_bytes.delete();
        end else begin
            case (d_ph)
                0: if (tx == 1'b0) begin d_ph = 1; d_cnt = N / 2; end
                1: begin
                    d_cnt--;
                    if (d_cnt == 0) begin
                        check("start_bit", 64'(tx), 64'd0);
                        d_ph = 2; d_cnt = N; d_bit = 0;
                    end
                end
                2: begin
                    d_cnt--;
                    if (d_cnt == 0) begin
                        d_sh[d_bit] = tx;
                        d_cnt = N;
                        if (d_bit == 7) d_ph = 3;
                        else d_bit++;
                    end
                end
                default: begin
                    d_cnt--;
                    if (d_cnt == 0) begin
                        check("stop_bit", 64'(tx), 64'd1);
                        rx_bytes.push_back(d_sh);
                        if (rx_bytes.size() == 5) begin
                            rx_frames.push_back({rx_bytes[0], rx_bytes[1], rx_bytes[2],
                                                 rx_bytes[3], rx_bytes[4]});
                            rx_bytes.delete();
                        end
                        d_ph = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] last_sent[$];
    logic [39:0] last_rx[$];

    task automatic pulse(input logic [15:0] a, input logic [15:0] b);
        valid_snn = 1'b1;
        p1 = a;
        p2 = b;
        @(negedge wb_clk);
        valid_snn = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge wb_clk);
    endtask

    // Wait for model and line to go quiet, then compare everything sent.
    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (!(m_q.size() == 0 && cyc > m_last_pop + F + 4 && d_ph == 0) && budget < 20000) begin
            @(negedge wb_clk);
            budget++;
        end
        check({tag, "_timeout"}, 64'(budget < 20000), 64'd1);
        check({tag, "_nframes"}, 64'(rx_frames.size()), 64'(m_sent.size()));
        for (int i = 0; i < m_sent.size() && i < rx_frames.size(); i++)
            check({tag, "_frame"}, 64'(rx_frames[i]), 64'({SYNC, m_sent[i]}));
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frames % 65536));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
        check({tag, "_tx_idle"}, 64'(tx), 64'd1);
        last_sent = m_sent;
        last_rx   = rx_frames;
        m_sent.delete();
        rx_frames.delete();
    endtask

    initial begin
        wb_rst    = 1'b1;
        valid_snn = 1'b0;
        p1        = '0;
        p2        = '0;
        n_decim   = 32'd1;
        en        = 1'b1;
        idle(3);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        wb_rst = 1'b0;
        idle(2);

        // Single result: latency, content, completion time.
        pulse(16'h0123, 16'hFFFE);
        check("t1_tx_e0", 64'(tx), 64'd1);
        idle(1);
        check("t1_tx_e1", 64'(tx), 64'd1);
        idle(1);
        check("t1_start_bit", 64'(tx), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        idle(50 * N - 1);
        check("t1_cnt_before", 64'(frame_cnt), 64'd0);
        idle(1);
        check("t1_cnt_after", 64'(frame_cnt), 64'd1);
        drain("t1");
        check("t1_bytes", 64'(last_rx.size() > 0 ? last_rx[0] : 40'h0), 64'h00A50123FFFE);

        // Decimation by 150.
        n_decim = 32'd150;
        for (int i = 0; i < 450; i++) begin
            pulse(16'(i), 16'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain("t2");
        check("t2_count", 64'(last_sent.size()), 64'd3);
        for (int k = 0; k < 3 && k < last_sent.size(); k++)
            check("t2_p1", 64'(last_sent[k][31:16]), 64'(150 * k));

        // Full FIFO with a push landing on the pop edge.
        n_decim = 32'd1;
        for (int i = 0; i < 5; i++) pulse(16'(16'h100 + i), 16'($urandom));
        check("t4_ovf_before", 64'(overflow), 64'd0);
        idle(50 * N - 1);
        pulse(16'h0105, 16'h5555);
        check("t4_ovf_after", 64'(overflow), 64'd0);
        drain("t4");
        check("t4_count", 64'(last_sent.size()), 64'd6);

        // Overflow: 6 back-to-back captures, the 6th is dropped.
        for (int i = 0; i < 6; i++) pulse(16'(16'h200 + i), 16'($urandom));
        check("t3_ovf", 64'(overflow), 64'd1);
        drain("t3");
        check("t3_count", 64'(last_sent.size()), 64'd5);
        for (int k = 0; k < 5 && k < last_sent.size(); k++)
            check("t3_order", 64'(last_sent[k][31:16]), 64'(16'h200 + k));

        // Reset in the middle of byte 2 data bits.
        pulse(16'($urandom), 16'($urandom));
        idle(2 + 21 * N + 3 * N);
        #2 wb_rst = 1'b1;
        #1;
        check("t5_tx", 64'(tx), 64'd1);
        check("t5_frame_cnt", 64'(frame_cnt), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        idle(2);
        wb_rst = 1'b0;
        rx_frames.delete();
        idle(2);
        pulse(16'h7E81, 16'h8001);
        drain("t5");
        check("t5_count", 64'(last_sent.size()), 64'd1);

        // n_decim=0 captures every strobe; en=0 holds the decimator.
        n_decim = 32'd0;
        for (int i = 0; i < 3; i++) pulse(16'(16'h300 + i), 16'($urandom));
        drain("t6a");
        check("t6a_count", 64'(last_sent.size()), 64'd3);
        n_decim = 32'd3;
        en = 1'b0;
        for (int i = 0; i < 4; i++) pulse(16'hDEAD, 16'hBEEF);
        check("t6_en0_busy", 64'(busy), 64'd0);
        en = 1'b1; pulse(16'h0400, 16'h0001);
        en = 1'b0; for (int i = 0; i < 3; i++) pulse(16'hDEAD, 16'hBEEF);
        en = 1'b1;
        pulse(16'h0401, 16'h0002);
        pulse(16'h0402, 16'h0003);
        pulse(16'h0403, 16'h0004);
        pulse(16'h0404, 16'h0005);
        pulse(16'h0405, 16'h0006);
        drain("t6b");
        check("t6b_count", 64'(last_sent.size()), 64'd2);
        if (last_sent.size() == 2) begin
            check("t6b_first", 64'(last_sent[0][31:16]), 64'h0400);
            check("t6b_second", 64'(last_sent[1][31:16]), 64'h0403);
        end

        // Randomized traffic.
        n_decim = 32'($urandom_range(1, 3));
        for (int i = 0; i < 15; i++) begin
            en = ($urandom_range(0, 4) != 0);
            pulse(16'($urandom), 16'($urandom));
            idle($urandom_range(0, 300));
        end
        en = 1'b1;
        drain("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
